// File: rtl/conv_8x32_accumulator.sv
// conv_8x32_accumulator: accumulates a programmable number (1..MAX_LEN) of
// unsigned partial sums from the 8x32 adder stage into one saturating result,
// one window per start command, with valid/ready on both sides.
module conv_8x32_accumulator #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ACC_WIDTH  = 16,
  parameter int unsigned MAX_LEN    = 32,
  parameter int unsigned LEN_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  input  logic                  sum_valid_i,
  input  logic [DATA_WIDTH:0]   sum_i,
  output logic                  sum_ready_o,
  output logic                  acc_valid_o,
  output logic [ACC_WIDTH-1:0]  acc_o,
  input  logic                  acc_ready_i,
  output logic                  busy_o,
  output logic                  sat_o
);

  localparam int unsigned EXT_W = ACC_WIDTH + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
  logic [LEN_WIDTH-1:0] cnt_inc;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                 sat_q, sat_d;
  logic [EXT_W-1:0]     acc_sum;
  logic                 len_ok;

  // One extra bit on the adder exposes the overflow that triggers saturation
  assign acc_sum = EXT_W'(acc_q) + EXT_W'(sum_i);
  assign cnt_inc = cnt_q + LEN_WIDTH'(1);
  assign len_ok  = (len_i != '0) && (len_i <= LEN_WIDTH'(MAX_LEN));

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      sat_q   <= sat_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    sat_d   = sat_q;
    case (state_q)
      S_IDLE: begin
        if (start_i && len_ok) begin
          len_d   = len_i;
          cnt_d   = '0;
          acc_d   = '0;
          sat_d   = 1'b0;
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (sum_valid_i) begin
          if (acc_sum[ACC_WIDTH]) begin
            acc_d = '1;
            sat_d = 1'b1;
          end else begin
            acc_d = acc_sum[ACC_WIDTH-1:0];
          end
          cnt_d = cnt_inc;
          if (cnt_inc == len_q) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (acc_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are pure decodes of registered state, so they are glitch-free
  assign sum_ready_o = (state_q == S_ACCUM);
  assign acc_valid_o = (state_q == S_DONE);
  assign busy_o      = (state_q != S_IDLE);
  assign sat_o       = (state_q == S_DONE) && sat_q;
  assign acc_o       = acc_q;

endmodule

// File: doc/conv_8x32_accumulator.md
Name: conv_8x32_accumulator

Overview:
Downstream consumer of the 8x32 convolution adder stage. It takes the stream of (DATA_WIDTH+1)-bit partial sums over a valid/ready handshake and accumulates a programmable number of terms (1..32) into one convolution output. It then presents the result on a valid/ready output port. One accumulation window runs per start command.

Parameters:
DATA_WIDTH, 8, operand width of the upstream adder; the input sum is DATA_WIDTH+1 bits wide
ACC_WIDTH, 16, accumulator and result width; must be >= DATA_WIDTH+1
MAX_LEN, 32, maximum number of terms per window
LEN_WIDTH, 6, width of len_i; must hold MAX_LEN

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
start_i  input  1  one-cycle pulse; begins a window; honoured only in IDLE
len_i  input  LEN_WIDTH  number of terms in the window; sampled when start_i is accepted
sum_valid_i  input  1  upstream partial sum valid
sum_i  input  DATA_WIDTH+1  unsigned partial sum from the adder stage
sum_ready_o  output  1  accumulator can take sum_i
acc_valid_o  output  1  result valid
acc_o  output  ACC_WIDTH  accumulated result
acc_ready_i  input  1  downstream accepts the result
busy_o  output  1  high whenever not in IDLE
sat_o  output  1  high with acc_valid_o if saturation occurred in this window

Behaviour:
- Reset (asynchronous assert, synchronous deassert by clk): state=IDLE, acc register=0, term counter=0.
  - Outputs at reset: sum_ready_o=0, acc_valid_o=0, acc_o=0, busy_o=0, sat_o=0.
- FSM states: IDLE, ACCUM, DONE.
- IDLE:
  - start_i=1 with 1<=len_i<=MAX_LEN: latch len_i, clear acc and sat, counter=0, go to ACCUM next cycle.
  - start_i with len_i=0 or len_i>MAX_LEN: ignored; remain in IDLE.
- ACCUM:
  - sum_ready_o=1 combinationally while in ACCUM.
  - Transfer occurs when sum_valid_i && sum_ready_o.
  - On a transfer: acc <= acc + zero-extended sum_i; counter increments.
  - Transfer of the len-th term: go to DONE next cycle.
  - No transfer (sum_valid_i=0): hold acc and counter.
  - start_i in ACCUM or DONE: ignored.
- Arithmetic:
  - Unsigned.
  - If acc + sum_i exceeds 2^ACC_WIDTH-1, acc saturates at all-ones and the sticky sat flag sets.
  - Further terms keep acc at all-ones.
- DONE:
  - acc_valid_o=1, acc_o=acc, sat_o=sat flag, sum_ready_o=0.
  - acc_o and sat_o are stable while acc_valid_o=1 and acc_ready_i=0.
  - acc_valid_o && acc_ready_i: go to IDLE next cycle, acc_valid_o drops.
  - acc_o keeps the last result in IDLE until the next accepted start clears it.
- Latency:
  - First term can be accepted 1 cycle after start_i.
  - With sum_valid_i held high, acc_valid_o rises len cycles after the first transfer cycle, i.e. len+1 cycles after start_i.
- Throughput: one term per cycle; one idle cycle between windows (the DONE->IDLE->start path).
- Reset mid-window: everything returns to reset values immediately; the partial window is discarded.
- busy_o = (state != IDLE).

Test Plan:
- Basic window: start_i with len_i=4, sums 10,20,30,40 with valid held high -> acc_valid_o exactly 5 cycles after start_i, acc_o=100, sat_o=0, sum_ready_o low in DONE.
- Full window with max values: len_i=32, all sums=510 -> acc_o=16320, sat_o=0, exactly 32 transfers accepted.
- Gapped valid and backpressure:
  - len_i=3, sums 1,2,3 with sum_valid_i low for 2 cycles between terms -> acc_o=6.
  - acc_ready_i held low 5 cycles -> acc_o/acc_valid_o stable; IDLE the cycle after acc_ready_i=1.
- Saturation: ACC_WIDTH=10 build, len_i=3, sums 500,500,500 -> acc_o=1023, sat_o=1. The next window of len_i=1, sum=7 -> acc_o=7, sat_o=0.
- Illegal and ignored starts:
  - len_i=0 -> stays IDLE, busy_o=0.
  - len_i=33 -> ignored.
  - start_i pulsed during ACCUM with len_i=2 -> original len_i=4 window completes unaffected.
- Reset mid-operation: rst_n low after 2 of 4 terms -> all outputs 0 immediately. The following window of len_i=2, sums 5,6 -> acc_o=11.
